// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receiver: frame FSM states, prefix
// bytes and the width of one decoded FIFO entry.
package ps2_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // {ext, brk, code[7:0]}
  localparam int unsigned PS2_ENTRY_W = 10;

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// Decoded-key read port: valid/ready handshake carrying one scan code and its
// E0 / F0 prefix flags.
interface ps2_rx_fifo_if;
  logic       key_valid;
  logic       key_ready;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_brk;

  modport master (
    output key_valid,
    output key_code,
    output key_ext,
    output key_brk,
    input  key_ready
  );

  modport slave (
    input  key_valid,
    input  key_code,
    input  key_ext,
    input  key_brk,
    output key_ready
  );
endinterface

// File: rtl/ps2_glitch_filter.sv
// Two-flop synchroniser followed by a FILTER_LEN-deep majority-free filter: the
// output only moves once every stored sample agrees. Emits a falling-edge strobe.
module ps2_glitch_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic fall
);

  logic [1:0]            sync_q;
  logic [FILTER_LEN-1:0] shift_q;
  logic                  level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      shift_q <= '1;
      level_q <= 1'b1;
    end else begin
      sync_q  <= {sync_q[0], din};
      shift_q <= {shift_q[FILTER_LEN-2:0], sync_q[1]};
      if (&shift_q) begin
        level_q <= 1'b1;
      end else if (~|shift_q) begin
        level_q <= 1'b0;
      end
    end
  end

  assign dout = level_q;
  // High for exactly the one cycle before level_q drops.
  assign fall = level_q & ~|shift_q;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: filtered line sampling, frame checking with timeout,
// E0/F0 prefix decode and a first-word-fall-through scan-code FIFO.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned TIMEOUT_CYC = 20000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ps2_clk,
  input  logic                 ps2_data,
  ps2_rx_fifo_if.master        key,
  output logic [15:0]          last_code,
  output logic                 err_parity,
  output logic                 err_frame,
  output logic                 overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC);

  logic clk_lvl_unused, clk_fall, data_lvl, data_fall_unused;

  ps2_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ps2_clk),
    .dout  (clk_lvl_unused),
    .fall  (clk_fall)
  );

  ps2_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ps2_data),
    .dout  (data_lvl),
    .fall  (data_fall_unused)
  );

  ps2_state_e state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_ok_q, par_ok_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          frame_err, parity_err, byte_done;

  logic          good_q;
  logic [7:0]    byte_q;
  logic [15:0]   last_code_q;
  logic          err_parity_q, err_frame_q, overflow_q;
  logic          ext_pend_q, brk_pend_q;

  logic [AW:0]   wptr_q, rptr_q;
  logic [PS2_ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [PS2_ENTRY_W-1:0] head;
  logic          empty, full, pop, push_req, push, drop;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_ok_d   = par_ok_q;
    tmo_d      = '0;
    frame_err  = 1'b0;
    parity_err = 1'b0;
    byte_done  = 1'b0;

    if (state_q != StIdle && !clk_fall) begin
      tmo_d = tmo_q + TW'(1);
    end

    case (state_q)
      StIdle: begin
        if (clk_fall) begin
          if (!data_lvl) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end else begin
            frame_err = 1'b1;
          end
        end
      end
      StData: begin
        if (clk_fall) begin
          shift_d = {data_lvl, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = StParity;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      StParity: begin
        if (clk_fall) begin
          par_ok_d = ^{shift_q, data_lvl};
          state_d  = StStop;
        end
      end
      StStop: begin
        if (clk_fall) begin
          state_d = StIdle;
          if (!data_lvl) begin
            frame_err = 1'b1;
          end else if (!par_ok_q) begin
            parity_err = 1'b1;
          end else begin
            byte_done = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Stalled sender: abandon the partial frame.
    if (state_q != StIdle && !clk_fall && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
      state_d   = StIdle;
      tmo_d     = '0;
      frame_err = 1'b1;
    end
  end

  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop      = !empty && key.key_ready;
  assign push_req = good_q && (byte_q != PS2_EXT) && (byte_q != PS2_BRK);
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_ok_q     <= 1'b0;
      tmo_q        <= '0;
      good_q       <= 1'b0;
      byte_q       <= '0;
      last_code_q  <= '0;
      err_parity_q <= 1'b0;
      err_frame_q  <= 1'b0;
      overflow_q   <= 1'b0;
      ext_pend_q   <= 1'b0;
      brk_pend_q   <= 1'b0;
      wptr_q       <= '0;
      rptr_q       <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_ok_q     <= par_ok_d;
      tmo_q        <= tmo_d;
      good_q       <= byte_done;
      err_parity_q <= parity_err;
      err_frame_q  <= frame_err;
      if (byte_done) begin
        byte_q      <= shift_q;
        last_code_q <= {last_code_q[7:0], shift_q};
      end
      if (frame_err || parity_err) begin
        ext_pend_q <= 1'b0;
        brk_pend_q <= 1'b0;
      end else if (good_q) begin
        if (byte_q == PS2_EXT) begin
          ext_pend_q <= 1'b1;
        end else if (byte_q == PS2_BRK) begin
          brk_pend_q <= 1'b1;
        end else begin
          ext_pend_q <= 1'b0;
          brk_pend_q <= 1'b0;
        end
      end
      if (push) begin
        wptr_q <= wptr_q + (AW+1)'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + (AW+1)'(1);
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= {ext_pend_q, brk_pend_q, byte_q};
    end
  end

  assign head          = mem_q[rptr_q[AW-1:0]];
  // Gate the head so an empty (or just-reset) FIFO presents zeros.
  assign key.key_valid = !empty;
  assign key.key_code  = empty ? 8'h00 : head[7:0];
  assign key.key_ext   = !empty && head[9];
  assign key.key_brk   = !empty && head[8];

  assign last_code  = last_code_q;
  assign err_parity = err_parity_q;
  assign err_frame  = err_frame_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: drives PS/2 frames bit by bit and checks
// decoded entries, error pulses, overflow, timeout and reset behaviour.
module tb_ps2_rx_fifo;

  localparam int unsigned FL   = 4;
  localparam int unsigned FD   = 4;
  localparam int unsigned TC   = 2000;
  localparam int unsigned HALF = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] last_code;
  logic        err_parity, err_frame, overflow;

  ps2_rx_fifo_if key ();

  ps2_rx_fifo #(
    .FILTER_LEN  (FL),
    .FIFO_DEPTH  (FD),
    .TIMEOUT_CYC (TC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .key        (key),
    .last_code  (last_code),
    .err_parity (err_parity),
    .err_frame  (err_frame),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int par_cnt = 0;
  int frm_cnt = 0;
  int valid_cnt = 0;
  logic [9:0] got[$];

  // Observe outputs 1 time unit after the falling edge, after inputs settle.
  always @(negedge clk) begin
    #1;
    if (err_parity) par_cnt++;
    if (err_frame) frm_cnt++;
    if (key.key_valid) valid_cnt++;
    if (key.key_valid && key.key_ready) got.push_back({key.key_ext, key.key_brk, key.key_code});
  end

  initial begin
    #950000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr();
    par_cnt = 0;
    frm_cnt = 0;
    valid_cnt = 0;
    got.delete();
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    cyc(HALF);
    ps2_clk = 1'b0;
    cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~^b ^ flip);
    send_bit(1'b1);
    cyc(20);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(3);
    n_checks++;
    if ({key.key_valid, key.key_code, key.key_ext, key.key_brk} !== 11'h0) begin
      n_fail++;
      $display("FAIL reset_key: got v=%b c=%h e=%b b=%b required all 0",
               key.key_valid, key.key_code, key.key_ext, key.key_brk);
    end
    n_checks++;
    if ({last_code, err_parity, err_frame, overflow} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_status: got last=%h ep=%b ef=%b ov=%b required all 0",
               last_code, err_parity, err_frame, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(10);
  endtask

  task automatic test_make();
    clr();
    send_frame(8'h1C, 1'b0);
    n_checks++;
    if (got.size() != 1 || got[0] !== 10'h01C) begin
      n_fail++;
      $display("FAIL make_entry: got n=%0d e=%h required n=1 e=01c", got.size(),
               (got.size() > 0) ? got[0] : 10'h3FF);
    end
    n_checks++;
    if (valid_cnt != 1) begin
      n_fail++;
      $display("FAIL make_valid_width: got %0d cycles required 1", valid_cnt);
    end
    n_checks++;
    if (last_code !== 16'h001C) begin
      n_fail++;
      $display("FAIL make_last: got %h required 001c", last_code);
    end
    n_checks++;
    if (par_cnt != 0 || frm_cnt != 0) begin
      n_fail++;
      $display("FAIL make_errs: got par=%0d frm=%0d required 0 0", par_cnt, frm_cnt);
    end
  endtask

  task automatic test_ext_brk();
    clr();
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    n_checks++;
    if (got.size() != 1 || got[0] !== 10'h375) begin
      n_fail++;
      $display("FAIL extbrk_entry: got n=%0d e=%h required n=1 e=375", got.size(),
               (got.size() > 0) ? got[0] : 10'h3FF);
    end
    n_checks++;
    if (last_code !== 16'hF075) begin
      n_fail++;
      $display("FAIL extbrk_last: got %h required f075", last_code);
    end
  endtask

  task automatic test_parity();
    clr();
    send_frame(8'hE0, 1'b0);
    send_frame(8'h1C, 1'b1);
    n_checks++;
    if (par_cnt != 1 || frm_cnt != 0) begin
      n_fail++;
      $display("FAIL parity_pulse: got par=%0d frm=%0d required 1 0", par_cnt, frm_cnt);
    end
    n_checks++;
    if (got.size() != 0) begin
      n_fail++;
      $display("FAIL parity_noentry: got n=%0d required 0", got.size());
    end
    send_frame(8'h1C, 1'b0);
    n_checks++;
    if (got.size() != 1 || got[0] !== 10'h01C) begin
      n_fail++;
      $display("FAIL parity_extdrop: got n=%0d e=%h required n=1 e=01c", got.size(),
               (got.size() > 0) ? got[0] : 10'h3FF);
    end
    n_checks++;
    if (last_code !== 16'hE01C) begin
      n_fail++;
      $display("FAIL parity_last: got %h required e01c", last_code);
    end
  endtask

  task automatic test_timeout();
    int lat;
    clr();
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge clk);
    ps2_data = 1'b1;
    cyc(HALF);
    ps2_clk = 1'b0;
    lat = -1;
    for (int k = 1; k <= 2500; k++) begin
      @(negedge clk);
      if (k == HALF) ps2_clk = 1'b1;
      #1;
      if (err_frame && lat < 0) lat = k;
    end
    // 2 sync + FL filter + 1 strobe + TC count cycles after the pin falls.
    n_checks++;
    if (lat < 1995 || lat > 2015) begin
      n_fail++;
      $display("FAIL timeout_latency: got %0d cycles required about 2007", lat);
    end
    n_checks++;
    if (frm_cnt != 1 || got.size() != 0) begin
      n_fail++;
      $display("FAIL timeout_pulse: got frm=%0d n=%0d required 1 0", frm_cnt, got.size());
    end
    send_frame(8'h29, 1'b0);
    n_checks++;
    if (got.size() != 1 || got[0] !== 10'h029 || frm_cnt != 1) begin
      n_fail++;
      $display("FAIL timeout_recover: got n=%0d e=%h frm=%0d required n=1 e=029 frm=1",
               got.size(), (got.size() > 0) ? got[0] : 10'h3FF, frm_cnt);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_code;
    @(negedge clk);
    key.key_ready = 1'b0;
    clr();
    for (int i = 0; i < 5; i++) send_frame(8'h15 + 8'(i), 1'b0);
    n_checks++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_flag: got %b required 1", overflow);
    end
    n_checks++;
    if (key.key_valid !== 1'b1 || key.key_code !== 8'h15) begin
      n_fail++;
      $display("FAIL ovf_head: got v=%b c=%h required v=1 c=15", key.key_valid, key.key_code);
    end
    @(negedge clk);
    key.key_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_code = 8'h15 + 8'(i);
      n_checks++;
      if (key.key_valid !== 1'b1 || key.key_code !== exp_code) begin
        n_fail++;
        $display("FAIL ovf_drain%0d: got v=%b c=%h required v=1 c=%h", i, key.key_valid,
                 key.key_code, exp_code);
      end
      @(negedge clk);
      #1;
    end
    n_checks++;
    if (key.key_valid !== 1'b0 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_empty: got v=%b ov=%b required v=0 ov=1", key.key_valid, overflow);
    end
  endtask

  task automatic test_glitch();
    clr();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ps2_clk = 1'b0;
      @(negedge clk);
      ps2_clk = 1'b1;
      cyc(30);
    end
    cyc(50);
    n_checks++;
    if (frm_cnt != 0 || par_cnt != 0 || got.size() != 0 || valid_cnt != 0) begin
      n_fail++;
      $display("FAIL glitch_ignored: got frm=%0d par=%0d n=%0d v=%0d required all 0",
               frm_cnt, par_cnt, got.size(), valid_cnt);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    key.key_ready = 1'b0;
    clr();
    send_frame(8'h1C, 1'b0);
    n_checks++;
    if (key.key_valid !== 1'b1 || last_code !== 16'h191C) begin
      n_fail++;
      $display("FAIL rstmid_pre: got v=%b last=%h required v=1 last=191c",
               key.key_valid, last_code);
    end
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({key.key_valid, key.key_code, key.key_ext, key.key_brk} !== 11'h0) begin
      n_fail++;
      $display("FAIL rstmid_key: got v=%b c=%h e=%b b=%b required all 0",
               key.key_valid, key.key_code, key.key_ext, key.key_brk);
    end
    n_checks++;
    if ({last_code, err_parity, err_frame, overflow} !== 19'h0) begin
      n_fail++;
      $display("FAIL rstmid_status: got last=%h ep=%b ef=%b ov=%b required all 0",
               last_code, err_parity, err_frame, overflow);
    end
    cyc(5);
    rst_n = 1'b1;
    cyc(20);
    n_checks++;
    if (key.key_valid !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_after: got v=%b ov=%b required 0 0", key.key_valid, overflow);
    end
  endtask

  initial begin
    key.key_ready = 1'b1;
    test_reset();
    test_make();
    test_ext_brk();
    test_parity();
    test_timeout();
    test_overflow();
    test_glitch();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
